// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver that turns the asynchronous rx line into
// byte strobes. Frames are 8N1, LSB first, with each bit sampled at mid-bit.
// Optional even-parity bit between the data and the stop bit is enabled by
// defining the macro UART_RX_PARITY_EN; without it parity_error stays 0.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       io_data_valid,
  output logic [7:0] io_data_packet,
  output logic       frame_error,
  output logic       parity_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    s_wait_idle = 3'd0,
    s_idle      = 3'd1,
    s_start     = 3'd2,
    s_data      = 3'd3,
`ifdef UART_RX_PARITY_EN
    s_parity    = 3'd5,
`endif
    s_stop      = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [7:0]             shift_reg;
  logic                   bit_done;
  logic                   parity_ok;
  logic                   valid_d;
  logic                   ferr_d;
  logic                   perr_d;

  // Bring the asynchronous line into the clk domain; resets to idle-high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_serial};
    end
  end

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign bit_done = (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= s_wait_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: walk the frame, abandoning it on a glitchy start bit
  always_comb begin
    state_nxt = state;
    unique case (state)
      s_wait_idle: begin
        if (rx_s) state_nxt = s_idle;
      end
      s_idle: begin
        if (!rx_s) state_nxt = s_start;
      end
      s_start: begin
        if (cnt == HALF) state_nxt = rx_s ? s_idle : s_data;
      end
      s_data: begin
        if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_nxt = s_parity;
`else
          state_nxt = s_stop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      s_parity: begin
        if (bit_done) state_nxt = s_stop;
      end
`endif
      s_stop: begin
        if (bit_done) state_nxt = rx_s ? s_idle : s_wait_idle;
      end
      default: state_nxt = s_wait_idle;
    endcase
  end

  // Bit timing counter, bit index and LSB-first shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      unique case (state)
        s_wait_idle, s_idle: begin
          cnt <= '0;
        end
        s_start: begin
          if (cnt == HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        s_data: begin
          if (bit_done) begin
            cnt       <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        s_parity: begin
          cnt <= bit_done ? '0 : cnt + 1'b1;
        end
`endif
        s_stop: begin
          cnt <= bit_done ? '0 : cnt + 1'b1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parity_ok_q;

  // Capture whether data plus parity bit XOR to zero (even parity)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_ok_q <= 1'b1;
    end else if ((state == s_parity) && bit_done) begin
      parity_ok_q <= ~(^{shift_reg, rx_s});
    end
  end

  assign parity_ok = parity_ok_q;
`else
  assign parity_ok = 1'b1;
`endif

  // Output decode at the mid-stop-bit sample; frame error beats parity error
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
    if ((state == s_stop) && bit_done) begin
      if (!rx_s) begin
        ferr_d = 1'b1;
      end else if (!parity_ok) begin
        perr_d = 1'b1;
      end else begin
        valid_d = 1'b1;
      end
    end
  end

  // Register the strobes; the packet only changes on a good byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_data_valid  <= 1'b0;
      frame_error    <= 1'b0;
      parity_error   <= 1'b0;
      io_data_packet <= 8'h00;
    end else begin
      io_data_valid <= valid_d;
      frame_error   <= ferr_d;
      parity_error  <= perr_d;
      if (valid_d) io_data_packet <= shift_reg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives directed UART frames into uart_rx and compares its
// strobes and held packet against a frame-level model of the receiver.
module tb_uart_rx;

  localparam int CLKS_PER_BIT = 16;
  localparam int SYNC_STAGES  = 2;
  localparam int HALF         = (CLKS_PER_BIT - 1) / 2;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam bit PAR_EN     = 1'b1;
`else
  localparam int FRAME_BITS = 10;
  localparam bit PAR_EN     = 1'b0;
`endif
  // Line start-edge to strobe: synchronizer plus mid-start plus bits to stop sample plus 2
  localparam int LATENCY = SYNC_STAGES + HALF + (FRAME_BITS - 1) * CLKS_PER_BIT + 2;

  localparam logic [2:0] K_VALID = 3'b100;
  localparam logic [2:0] K_FERR  = 3'b010;
  localparam logic [2:0] K_PERR  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_serial;
  logic       io_data_valid;
  logic [7:0] io_data_packet;
  logic       frame_error;
  logic       parity_error;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         n_valid = 0;
  int         n_ferr = 0;
  int         n_perr = 0;
  int         last_strobe_cyc = 0;
  logic [7:0] model_packet = 8'h00;
  exp_t       exp_q[$];
  exp_t       cur;
  int         diff;
  int         t0;
  int         lat;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_serial     (rx_serial),
    .io_data_valid (io_data_valid),
    .io_data_packet(io_data_packet),
    .frame_error   (frame_error),
    .parity_error  (parity_error)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Receiver rules at frame level: bad stop wins, then parity, else good byte
  function automatic logic [2:0] model_kind(input logic [7:0] data, input logic stop_bit, input logic par_bit);
    if (!stop_bit) return K_FERR;
    if (PAR_EN && ((^data) ^ par_bit)) return K_PERR;
    return K_VALID;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx_serial = b;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send one frame starting now, queue the outcome the model predicts
  task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input logic par_bit,
                                input int low_after, input int idle_after);
    exp_t e;
    e.kind = model_kind(data, stop_bit, par_bit);
    e.data = data;
    e.due  = cyc + LATENCY;
    exp_q.push_back(e);
    drive_bit(1'b0, CLKS_PER_BIT);
    for (int i = 0; i < 8; i++) drive_bit(data[i], CLKS_PER_BIT);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit, CLKS_PER_BIT);
`endif
    drive_bit(stop_bit, CLKS_PER_BIT);
    drive_bit(1'b0, low_after);
    drive_bit(1'b1, idle_after);
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (reset) begin
      check_output("reset_outputs", {21'd0, io_data_valid, frame_error, parity_error, io_data_packet}, 32'd0);
      exp_q.delete();
      model_packet = 8'h00;
    end else begin
      while ((exp_q.size() > 0) && (cyc > exp_q[0].due + 1)) begin
        check_output("missed_strobe_cycle", 32'(cyc), 32'(exp_q[0].due));
        void'(exp_q.pop_front());
      end
      if (io_data_valid || frame_error || parity_error) begin
        n_valid += int'(io_data_valid);
        n_ferr  += int'(frame_error);
        n_perr  += int'(parity_error);
        last_strobe_cyc = cyc;
        check_output("one_strobe", {30'd0, 2'(io_data_valid) + 2'(frame_error) + 2'(parity_error)}, 32'd1);
        if (exp_q.size() == 0) begin
          check_output("unexpected_strobe", {29'd0, io_data_valid, frame_error, parity_error}, 32'd0);
        end else begin
          cur  = exp_q.pop_front();
          diff = cyc - cur.due;
          check_output("strobe_kind", {29'd0, io_data_valid, frame_error, parity_error}, {29'd0, cur.kind});
          check_output("strobe_time", 32'((diff >= -1 && diff <= 1) ? cur.due : cyc), 32'(cur.due));
          if (cur.kind == K_VALID) model_packet = cur.data;
        end
      end
      check_output("packet_hold", {24'd0, io_data_packet}, {24'd0, model_packet});
    end
  end

  // Directed scenarios
  initial begin
    reset     = 1'b1;
    rx_serial = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    check_output("post_reset_packet", {24'd0, io_data_packet}, 32'h00);
    drive_bit(1'b1, 10);

    // 1: single frame 0xA5, latency from the line edge (155 = 153 + 2 sync)
    $display("[TB] frame 0xA5");
    t0 = cyc;
    apply_stimulus(8'hA5, 1'b1, ^8'hA5, 0, 10);
    lat = last_strobe_cyc - t0;
    check_output("t1_latency", 32'((lat >= 154 && lat <= 156) ? 155 : lat), 32'd155);
    check_output("t1_valid_count", 32'(n_valid), 32'd1);
    check_output("t1_packet", {24'd0, io_data_packet}, 32'hA5);
    check_output("t1_ferr_count", 32'(n_ferr), 32'd0);

    // 2: back-to-back 0x00 then 0xFF with no idle gap
    $display("[TB] back-to-back 0x00 0xFF");
    apply_stimulus(8'h00, 1'b1, 1'b0, 0, 0);
    apply_stimulus(8'hFF, 1'b1, 1'b0, 0, 10);
    check_output("t2_valid_count", 32'(n_valid), 32'd3);
    check_output("t2_packet", {24'd0, io_data_packet}, 32'hFF);

    // 3: 4-cycle glitch, then 0x3C
    $display("[TB] start glitch then 0x3C");
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    check_output("t3_glitch_valid_count", 32'(n_valid), 32'd3);
    apply_stimulus(8'h3C, 1'b1, ^8'h3C, 0, 10);
    check_output("t3_packet", {24'd0, io_data_packet}, 32'h3C);

    // 4: 0x12, then 0x55 with a bad stop bit and a held-low line, then 0x81
    $display("[TB] frame error recovery");
    apply_stimulus(8'h12, 1'b1, ^8'h12, 0, 5);
    apply_stimulus(8'h55, 1'b0, ^8'h55, 40, 20);
    check_output("t4_ferr_count", 32'(n_ferr), 32'd1);
    check_output("t4_valid_count", 32'(n_valid), 32'd5);
    check_output("t4_packet_kept", {24'd0, io_data_packet}, 32'h12);
    apply_stimulus(8'h81, 1'b1, ^8'h81, 0, 10);
    check_output("t4_packet_next", {24'd0, io_data_packet}, 32'h81);

    // 5: reset after four data bits of 0xF0, then 0x81
    $display("[TB] reset mid-frame");
    drive_bit(1'b0, CLKS_PER_BIT);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, CLKS_PER_BIT);
    reset = 1'b1;
    drive_bit(1'b1, 3);
    reset = 1'b0;
    drive_bit(1'b1, 20);
    check_output("t5_no_partial_valid", 32'(n_valid), 32'd6);
    check_output("t5_packet_cleared", {24'd0, io_data_packet}, 32'h00);
    apply_stimulus(8'h81, 1'b1, ^8'h81, 0, 10);
    check_output("t5_packet", {24'd0, io_data_packet}, 32'h81);
    check_output("t5_valid_count", 32'(n_valid), 32'd7);

`ifdef UART_RX_PARITY_EN
    // 6: even parity good and bad on 0x07
    $display("[TB] parity checks");
    apply_stimulus(8'h07, 1'b1, 1'b1, 0, 10);
    check_output("t6_packet_good", {24'd0, io_data_packet}, 32'h07);
    apply_stimulus(8'h07, 1'b1, 1'b0, 0, 10);
    check_output("t6_perr_count", 32'(n_perr), 32'd1);
    check_output("t6_valid_count", 32'(n_valid), 32'd8);
    check_output("t6_packet_kept", {24'd0, io_data_packet}, 32'h07);
`endif

    drive_bit(1'b1, 200);
    check_output("pending_strobes", 32'(exp_q.size()), 32'd0);
    check_output("perr_without_parity", 32'(PAR_EN ? 0 : n_perr), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
